serial_byte_receiver: RTL and testbench
=======================================

Name: serial_byte_receiver

Overview:
- Serial-in, parallel-out receiver; the far end of the 8-bit shift-right link, which drives LSB first.
- Samples a framed bit stream on qualified bit strobes and reassembles DATA_WIDTH-bit words.
- Presents each word with a one-cycle valid pulse and a frame-error pulse.
- Sits between the serial line (or a loopback from the shifter) and the LEDR/HEX display logic.

Parameters:
- DATA_WIDTH, 8: number of data bits per frame; legal range 2..16.

Ports:
- clock  input  1  system clock; all state updates on the posedge.
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- bit_en  input  1  bit strobe; serial_in is sampled only on clock edges where bit_en=1.
- serial_in  input  1  serial line; idles high.
- data_out  output  DATA_WIDTH  last correctly framed word; holds its value between frames.
- data_valid  output  1  one-cycle pulse when data_out updates.
- frame_error  output  1  one-cycle pulse when a bad stop bit is seen (or a bad parity bit, with the option compiled in).
- busy  output  1  high whenever a frame is in progress (state != IDLE).

Behaviour:
- Frame format: start bit (0), then DATA_WIDTH data bits LSB first, [parity bit], then stop bit (1). One bit per bit_en strobe.
- Reset values: state=IDLE, shift register=0, bit count=0, data_out=0, data_valid=0, frame_error=0, busy=0.
- Reset asserted mid-frame aborts the frame. No valid or error pulse is produced.
- States: IDLE, DATA, [PARITY], STOP.
- IDLE:
  - bit_en=1 and serial_in=0: go to DATA, count=0.
  - bit_en=1 and serial_in=1: stay in IDLE.
- DATA, on bit_en=1:
  - shift right, inserting serial_in at the MSB; the first data bit ends up at bit 0 after DATA_WIDTH shifts.
  - count++.
  - when count==DATA_WIDTH-1 on this strobe: go to PARITY if compiled in, else STOP.
- STOP, on bit_en=1:
  - serial_in=1: data_out<=shift register and data_valid=1 on the next cycle only.
  - serial_in=0: frame_error=1 on the next cycle only; data_out unchanged.
  - either way, return to IDLE.
- Latency: the valid or error pulse is registered and asserts on the clock edge that samples the stop bit. It is visible for exactly one clock, regardless of bit_en.
- Cycles with bit_en=0 hold all state; data_valid and frame_error deassert.
- Back-to-back frames: a start bit may arrive on the very next strobe after the stop bit. No idle bit is required.
- A stop bit of 0 (break) is not treated as a new start bit. The receiver returns to IDLE and waits for the next 0 sampled in IDLE.
- busy rises on the edge that samples the start bit and falls on the edge that samples the stop bit.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- When defined:
  - PARITY state is inserted after DATA: one strobe, sampling an even-parity bit over the data bits.
  - Mismatch is recorded. In STOP, a mismatch produces frame_error=1, data_valid=0 and no data_out update, even if the stop bit is good.
- When undefined:
  - no PARITY state; STOP directly follows DATA.
  - frame length is DATA_WIDTH+2 strobes.

Test Plan:
- Reset, then idle line (serial_in=1, bit_en every 4th cycle for 20 strobes) -> busy=0, data_valid never asserts, data_out=0x00.
- Frame 0xA5 (bits 0,1,0,1,0,0,1,0,1,1), bit_en every cycle -> one-cycle data_valid; data_out=0xA5; busy high for 9 cycles.
- Frame 0x3C with stop bit 0 -> frame_error pulses once; data_valid=0; data_out keeps its previous value (0xA5).
- Back-to-back 0x01 then 0xFF, no idle gap -> two data_valid pulses 10 strobes apart; data_out=0x01 then 0xFF.
- Reset asserted after 4 data bits of 0x77 -> busy and data_out clear immediately. A following frame 0x12 is received correctly (data_out=0x12).
- With SERIAL_RX_PARITY_EN, frame 0x03 sent with parity bit 1 (wrong; even parity requires 0) -> frame_error=1, data_valid=0. Resending with parity bit 0 -> data_out=0x03.

Source files
------------

// File: rtl/serial_byte_receiver.sv
// -----------------------------------------------------------------------------
// serial_byte_receiver
//
// Serial-in, parallel-out receiver for an LSB-first framed bit stream.
// Frame: start bit (0), DATA_WIDTH data bits LSB first, optional even-parity
// bit, stop bit (1). One bit is consumed per bit_en strobe.
//
// Optional feature macro: SERIAL_RX_PARITY_EN
//   When defined, an even-parity bit follows the data bits and a parity
//   mismatch turns an otherwise good frame into a frame error.
//
// Parameters:
//   DATA_WIDTH   data bits per frame (2..16)
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   bit_en       bit strobe; serial_in sampled only when high
//   serial_in    serial line, idles high
//   data_out     last correctly framed word, held between frames
//   data_valid   one-cycle pulse when data_out updates
//   frame_error  one-cycle pulse on a bad stop (or parity) bit
//   busy         high while a frame is in progress
// -----------------------------------------------------------------------------
module serial_byte_receiver #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  bit_en,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [1:0] S_PARITY = 2'd2;
`endif
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q,  ferr_d;
    logic                  stop_ok;

`ifdef SERIAL_RX_PARITY_EN
    logic                  perr_q,  perr_d;

    // A good stop bit only completes the frame if the parity bit matched.
    assign stop_ok = serial_in & ~perr_q;
`else
    assign stop_ok = serial_in;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        if (bit_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!serial_in) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
`ifdef SERIAL_RX_PARITY_EN
                        perr_d  = 1'b0;
`endif
                    end
                end
                S_DATA: begin
                    // Bits arrive LSB first, so shifting right from the MSB
                    // leaves the first data bit at bit 0 after the last shift.
                    shift_d = {serial_in, shift_q[DATA_WIDTH-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                S_PARITY: begin
                    // Even parity: the parity bit equals the XOR of the data.
                    perr_d  = serial_in ^ (^shift_q);
                    state_d = S_STOP;
                end
`endif
                S_STOP: begin
                    if (stop_ok) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                    // A zero stop bit (break) is not a start bit; wait in IDLE.
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef SERIAL_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_byte_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_byte_receiver
//
// Self-checking bench for serial_byte_receiver. A frame-level reference model
// (bit position within the frame, collected data bits) predicts the outputs;
// a single stimulus/compare process checks them every cycle, plus literal
// expectations for the directed frames.
// -----------------------------------------------------------------------------
module tb_serial_byte_receiver;

    localparam int DW = 8;
`ifdef SERIAL_RX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif
    localparam int FLEN = DW + 2 + (PAR_ON ? 1 : 0);

    logic          clock;
    logic          reset;
    logic          bit_en;
    logic          serial_in;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          frame_error;
    logic          busy;

    serial_byte_receiver #(.DATA_WIDTH(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .bit_en      (bit_en),
        .serial_in   (serial_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // ---------------- reference model ----------------
    bit            m_act;
    int            m_pos;
    logic [15:0]   m_bits;
    logic          m_par;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_err;

    function automatic logic even_par(input logic [15:0] b);
        logic p = 1'b0;
        for (int i = 0; i < DW; i++) p ^= b[i];
        return p;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_act   <= 1'b0;
            m_pos   <= 0;
            m_bits  <= '0;
            m_par   <= 1'b0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            if (bit_en) begin
                if (!m_act) begin
                    if (!serial_in) begin
                        m_act <= 1'b1;
                        m_pos <= 0;
                    end
                end else if (m_pos < DW) begin
                    m_bits[m_pos[3:0]] <= serial_in;
                    m_pos <= m_pos + 1;
                end else if (PAR_ON && m_pos == DW) begin
                    m_par <= serial_in;
                    m_pos <= m_pos + 1;
                end else begin
                    if (serial_in && (!PAR_ON || even_par(m_bits) == m_par)) begin
                        m_data  <= m_bits[DW-1:0];
                        m_valid <= 1'b1;
                    end else begin
                        m_err <= 1'b1;
                    end
                    m_act <= 1'b0;
                end
            end
        end
    end

    // ---------------- observation counters ----------------
    int cyc       = 0;
    int busy_tot  = 0;
    int valid_tot = 0;
    int err_tot   = 0;
    int vq[$];
    logic [DW-1:0] vd[$];

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (busy)        busy_tot  <= busy_tot + 1;
        if (frame_error) err_tot   <= err_tot + 1;
        if (data_valid) begin
            valid_tot <= valid_tot + 1;
            vq.push_back(cyc);
            vd.push_back(data_out);
        end
    end

    // ---------------- checking / stimulus ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic en, input logic sin);
        @(negedge clock);
        if (chk_en) begin
            check("model data_out",    32'(data_out),    32'(m_data));
            check("model data_valid",  32'(data_valid),  32'(m_valid));
            check("model frame_error", 32'(frame_error), 32'(m_err));
            check("model busy",        32'(busy),        32'(m_act));
        end
        #1;
        bit_en    = en;
        serial_in = sin;
    endtask

    task automatic strobe(input logic b, input int gap);
        repeat (gap) tick(1'b0, 1'($urandom % 2));
        tick(1'b1, b);
    endtask

    task automatic send_frame(input logic [15:0] d, input logic stop_bit,
                              input logic par_flip, input int maxgap);
        strobe(1'b0, $urandom_range(0, maxgap));
        for (int i = 0; i < DW; i++) strobe(d[i], $urandom_range(0, maxgap));
        if (PAR_ON) strobe(even_par(d) ^ par_flip, $urandom_range(0, maxgap));
        strobe(stop_bit, $urandom_range(0, maxgap));
    endtask

    task automatic settle();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
    endtask

    int b0, v0, e0, n0;

    initial begin
        bit_en    = 1'b0;
        serial_in = 1'b1;
        reset     = 1'b0;
        #2;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("reset data_out", 32'(data_out), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset data_valid", 32'(data_valid), 32'h0);
        check("reset frame_error", 32'(frame_error), 32'h0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Idle line, strobe every 4th cycle.
        b0 = busy_tot; v0 = valid_tot;
        repeat (20) begin
            repeat (3) tick(1'b0, 1'b1);
            tick(1'b1, 1'b1);
        end
        settle();
        check("idle busy cycles", 32'(busy_tot - b0), 32'd0);
        check("idle valid pulses", 32'(valid_tot - v0), 32'd0);
        check("idle data_out", 32'(data_out), 32'h00);

        // 0xA5, strobe every cycle.
        b0 = busy_tot; v0 = valid_tot;
        send_frame(16'h00A5, 1'b1, 1'b0, 0);
        settle();
        check("A5 valid pulses", 32'(valid_tot - v0), 32'd1);
        check("A5 data_out", 32'(data_out), 32'hA5);
        check("A5 busy cycles", 32'(busy_tot - b0), 32'(FLEN - 1));

        // 0x3C with a zero stop bit.
        v0 = valid_tot; e0 = err_tot;
        send_frame(16'h003C, 1'b0, 1'b0, 0);
        settle();
        check("3C error pulses", 32'(err_tot - e0), 32'd1);
        check("3C valid pulses", 32'(valid_tot - v0), 32'd0);
        check("3C data_out held", 32'(data_out), 32'hA5);

        // Back-to-back 0x01 then 0xFF.
        n0 = vq.size();
        send_frame(16'h0001, 1'b1, 1'b0, 0);
        send_frame(16'h00FF, 1'b1, 1'b0, 0);
        settle();
        check("b2b pulse count", 32'(vq.size() - n0), 32'd2);
        if (vq.size() >= n0 + 2) begin
            check("b2b pulse spacing", 32'(vq[n0+1] - vq[n0]), 32'(FLEN));
            check("b2b first word", 32'(vd[n0]), 32'h01);
            check("b2b second word", 32'(vd[n0+1]), 32'hFF);
        end
        check("b2b data_out", 32'(data_out), 32'hFF);

        // Reset after 4 data bits of 0x77.
        strobe(1'b0, 0);
        for (int i = 0; i < 4; i++) strobe(1'($unsigned(8'h77) >> i), 0);
        tick(1'b0, 1'b1);
        check("pre-reset busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check("mid-frame reset busy", 32'(busy), 32'h0);
        check("mid-frame reset data_out", 32'(data_out), 32'h00);
        tick(1'b0, 1'b1);
        reset = 1'b0;
        v0 = valid_tot; e0 = err_tot;
        send_frame(16'h0012, 1'b1, 1'b0, 1);
        settle();
        check("post-reset data_out", 32'(data_out), 32'h12);
        check("post-reset valid pulses", 32'(valid_tot - v0), 32'd1);
        check("post-reset error pulses", 32'(err_tot - e0), 32'd0);

`ifdef SERIAL_RX_PARITY_EN
        v0 = valid_tot; e0 = err_tot;
        send_frame(16'h0003, 1'b1, 1'b1, 0);
        settle();
        check("parity bad error pulses", 32'(err_tot - e0), 32'd1);
        check("parity bad valid pulses", 32'(valid_tot - v0), 32'd0);
        check("parity bad data_out held", 32'(data_out), 32'h12);
        send_frame(16'h0003, 1'b1, 1'b0, 0);
        settle();
        check("parity good data_out", 32'(data_out), 32'h03);
`endif

        // Randomized frames with gaps, bad stops and bad parity.
        for (int f = 0; f < 150; f++) begin
            repeat ($urandom_range(0, 2)) strobe(1'b1, $urandom_range(0, 2));
            send_frame(16'($urandom), ($urandom % 8) != 0,
                       PAR_ON && (($urandom % 8) == 0), $urandom_range(0, 3));
        end

        // Unframed random bits.
        for (int k = 0; k < 300; k++) strobe(1'($urandom % 2), $urandom_range(0, 1));
        settle();
        check("random run produced words", 32'(valid_tot > 5), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
